// File: rtl/cpu5_memsys_pkg.sv
// Shared defines for the cpu5 memory system: default word width,
// controller state encodings and the registered response descriptor.
package cpu5_memsys_pkg;

  localparam int CPU5_XLEN = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic is_d;
    logic err;
    logic we;
  } rsp_info_t;

endpackage

// File: rtl/cpu5_memsys_sram_1rw.sv
// Single-port word array with per-byte write enables and a registered read port.
// Contents are deliberately left out of reset.
module cpu5_sram_1rw #(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           en,
  input  logic           we,
  input  logic [W/8-1:0] be,
  input  logic [AW-1:0]  addr,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        for (int i = 0; i < W / 8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cpu5_memsys.sv
// Instruction/data memory front end: round-robin arbiter, IDLE/WAIT/RESP
// controller and address error decode in front of one shared word array.
module cpu5_memsys
  import cpu5_memsys_pkg::*;
#(
  parameter int XLEN        = CPU5_XLEN,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  output logic              ireq_ready,
  input  logic [XLEN-1:0]   ireq_addr,
  output logic              irsp_valid,
  output logic [XLEN-1:0]   irsp_data,
  output logic              irsp_err,
  input  logic              dreq_valid,
  output logic              dreq_ready,
  input  logic [XLEN-1:0]   dreq_addr,
  input  logic              dreq_we,
  input  logic [XLEN/8-1:0] dreq_be,
  input  logic [XLEN-1:0]   dreq_wdata,
  output logic              drsp_valid,
  output logic [XLEN-1:0]   drsp_rdata,
  output logic              drsp_err
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a request transfers on the rising edge where valid and ready
  // are both high; ready is only offered in IDLE, to the granted channel.
  logic [1:0]      state;
  logic [2:0]      wait_cnt;
  logic            last_i;
  rsp_info_t       rsp;
  logic            idle;
  logic            in_resp;
  logic            grant_d;
  logic            grant_i;
  logic            accept;
  logic [XLEN-1:0] sel_addr;
  logic            sel_err;
  logic [XLEN-1:0] sram_rdata;

  assign idle    = (state == ST_IDLE);
  assign in_resp = (state == ST_RESP);

  // On a tie the channel that was not served last wins.
  assign grant_d    = dreq_valid && (!ireq_valid || last_i);
  assign grant_i    = ireq_valid && !grant_d;
  assign ireq_ready = idle && grant_i;
  assign dreq_ready = idle && grant_d;
  assign accept     = idle && (grant_i || grant_d);

  assign sel_addr = grant_d ? dreq_addr : ireq_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (AW + 2)) != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      last_i   <= 1'b1;
      rsp      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp.is_d <= grant_d;
            rsp.err  <= sel_err;
            rsp.we   <= grant_d && dreq_we;
            last_i   <= grant_i;
            if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= 3'(WAIT_STATES - 1);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) state <= ST_RESP;
          else wait_cnt <= wait_cnt - 3'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes commit and reads sample at the accept edge; errored requests never touch the array.
  cpu5_sram_1rw #(
    .W     (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (accept && !sel_err),
    .we    (grant_d && dreq_we),
    .be    (dreq_be),
    .addr  (sel_addr[AW+1:2]),
    .wdata (dreq_wdata),
    .rdata (sram_rdata)
  );

  assign irsp_valid = in_resp && !rsp.is_d;
  assign drsp_valid = in_resp && rsp.is_d;
  assign irsp_err   = irsp_valid && rsp.err;
  assign drsp_err   = drsp_valid && rsp.err;
  assign irsp_data  = (irsp_valid && !rsp.err) ? sram_rdata : '0;
  assign drsp_rdata = (drsp_valid && !rsp.err && !rsp.we) ? sram_rdata : '0;

endmodule

// File: tb/tb_cpu5_memsys.sv
// Bench for cpu5_memsys: three instances (WAIT_STATES 1, 3, 0) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_cpu5_memsys;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [3];
  logic        iv    [3];
  logic        ir    [3];
  logic [31:0] ia    [3];
  logic        irv   [3];
  logic [31:0] ird   [3];
  logic        ie    [3];
  logic        dv    [3];
  logic        dr    [3];
  logic [31:0] da    [3];
  logic        dwe   [3];
  logic [3:0]  dbe   [3];
  logic [31:0] dwd   [3];
  logic        drv   [3];
  logic [31:0] drd   [3];
  logic        de    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    cpu5_memsys #(
      .XLEN        (32),
      .DEPTH       (256),
      .WAIT_STATES (WS)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n[g]),
      .ireq_valid (iv[g]),
      .ireq_ready (ir[g]),
      .ireq_addr  (ia[g]),
      .irsp_valid (irv[g]),
      .irsp_data  (ird[g]),
      .irsp_err   (ie[g]),
      .dreq_valid (dv[g]),
      .dreq_ready (dr[g]),
      .dreq_addr  (da[g]),
      .dreq_we    (dwe[g]),
      .dreq_be    (dbe[g]),
      .dreq_wdata (dwd[g]),
      .drsp_valid (drv[g]),
      .drsp_rdata (drd[g]),
      .drsp_err   (de[g])
    );
  end

  function automatic int ws_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic chk(input int g, input string name, input logic [31:0] act,
                     input logic [31:0] exp, input logic [31:0] mask);
    n_checks++;
    if (((act ^ exp) & mask) !== 32'h0) begin
      n_fail++;
      $display("FAIL u%0d %s: actual %h required %h (t=%0t)", g, name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy flag plus cycles elapsed since the accept edge.
  logic [31:0] m_mem      [3][256];
  logic [3:0]  m_known    [3][256];
  int          m_busy     [3];
  int          m_age      [3];
  bit          m_last_i   [3];
  bit          m_rsp_d    [3];
  bit          m_rsp_err  [3];
  logic [31:0] m_rsp_data [3];
  logic [31:0] m_rsp_mask [3];

  always @(posedge clk) begin
    bit          gd;
    bit          gi;
    logic [31:0] a;
    int          idx;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n[g]) begin
        m_busy[g]   = 0;
        m_last_i[g] = 1'b1;
      end else if (m_busy[g] == 0) begin
        gd = dv[g] && (!iv[g] || m_last_i[g]);
        gi = iv[g] && !gd;
        if (gd || gi) begin
          a            = gd ? da[g] : ia[g];
          m_rsp_d[g]   = gd;
          m_last_i[g]  = gi;
          m_busy[g]    = 1;
          m_age[g]     = 0;
          m_rsp_mask[g] = 32'hFFFF_FFFF;
          if ((a % 4) != 0 || a >= 32'd1024) begin
            m_rsp_err[g]  = 1'b1;
            m_rsp_data[g] = 32'h0;
          end else begin
            idx          = int'(a / 4);
            m_rsp_err[g] = 1'b0;
            if (gd && dwe[g]) begin
              for (int b = 0; b < 4; b++) begin
                if (dbe[g][b]) begin
                  m_mem[g][idx][b*8 +: 8] = dwd[g][b*8 +: 8];
                  m_known[g][idx][b]      = 1'b1;
                end
              end
              m_rsp_data[g] = 32'h0;
            end else begin
              m_rsp_data[g] = m_mem[g][idx];
              m_rsp_mask[g] = byte_mask(m_known[g][idx]);
            end
          end
        end
      end else if (m_age[g] == ws_of(g)) begin
        m_busy[g] = 0;
      end else begin
        m_age[g]++;
      end
    end
  end

  always @(negedge clk) begin
    bit rv;
    bit e_ir;
    bit e_dr;
    bit e_irv;
    bit e_drv;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n[g]) begin
        m_busy[g]   = 0;
        m_last_i[g] = 1'b1;
      end
      rv    = (m_busy[g] != 0) && (m_age[g] == ws_of(g));
      e_irv = rv && !m_rsp_d[g];
      e_drv = rv && m_rsp_d[g];
      e_ir  = (m_busy[g] == 0) && iv[g] && (!dv[g] || !m_last_i[g]);
      e_dr  = (m_busy[g] == 0) && dv[g] && (!iv[g] || m_last_i[g]);
      chk(g, "ireq_ready", 32'(ir[g]), 32'(e_ir), 32'h1);
      chk(g, "dreq_ready", 32'(dr[g]), 32'(e_dr), 32'h1);
      chk(g, "irsp_valid", 32'(irv[g]), 32'(e_irv), 32'h1);
      chk(g, "drsp_valid", 32'(drv[g]), 32'(e_drv), 32'h1);
      chk(g, "irsp_err", 32'(ie[g]), 32'(e_irv && m_rsp_err[g]), 32'h1);
      chk(g, "drsp_err", 32'(de[g]), 32'(e_drv && m_rsp_err[g]), 32'h1);
      chk(g, "irsp_data", ird[g], e_irv ? m_rsp_data[g] : 32'h0,
          e_irv ? m_rsp_mask[g] : 32'hFFFF_FFFF);
      chk(g, "drsp_rdata", drd[g], e_drv ? m_rsp_data[g] : 32'h0,
          e_drv ? m_rsp_mask[g] : 32'hFFFF_FFFF);
      chk(g, "rsp_overlap", 32'(irv[g] && drv[g]), 32'h0, 32'h1);
    end
  end

  task automatic d_req(input int g, input bit we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input string name);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    dv[g] = 1'b1; dwe[g] = we; da[g] = a; dbe[g] = be; dwd[g] = wd;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (dr[g]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    dv[g] = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL u%0d %s_accept: actual no ready within 50 cycles required ready", g, name);
    end
  endtask

  task automatic wait_drsp(input int g, output int lat, output logic [31:0] data,
                           output logic err);
    lat  = 99;
    data = 32'hxxxx_xxxx;
    err  = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (drv[g]) begin
        lat  = n;
        data = drd[g];
        err  = de[g];
        break;
      end
    end
  endtask

  task automatic d_xact(input int g, input bit we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_data, input logic exp_err, input string name);
    int          lat;
    logic [31:0] data;
    logic        err;
    d_req(g, we, a, be, wd, name);
    wait_drsp(g, lat, data, err);
    chk(g, {name, "_latency"}, 32'(lat), 32'(exp_lat), 32'hFFFF_FFFF);
    chk(g, {name, "_data"}, data, exp_data, 32'hFFFF_FFFF);
    chk(g, {name, "_err"}, 32'(err), 32'(exp_err), 32'h1);
  endtask

  task automatic arb_test();
    bit got_q [$];
    bit exp_g [4];
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    iv[0] = 1'b1; ia[0] = 32'h10;
    dv[0] = 1'b1; da[0] = 32'h20; dwe[0] = 1'b0; dbe[0] = 4'hF;
    for (int n = 0; n < 60 && got_q.size() < 4; n++) begin
      @(negedge clk);
      if (dr[0]) got_q.push_back(1'b1);
      else if (ir[0]) got_q.push_back(1'b0);
    end
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    dv[0] = 1'b0;
    repeat (4) @(posedge clk);
    chk(0, "grant_count", 32'(got_q.size()), 32'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk(0, $sformatf("grant%0d_is_data", i), 32'(got_q[i]), 32'(exp_g[i]), 32'h1);
  endtask

  task automatic reset_abort_test();
    int seen;
    seen = 0;
    d_req(1, 1'b1, 32'h8, 4'hF, 32'hCAFE_F00D, "wr_8");
    @(posedge clk);
    #1;
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk(1, "abort_drsp_valid", 32'(drv[1]), 32'h0, 32'h1);
    chk(1, "abort_drsp_rdata", drd[1], 32'h0, 32'hFFFF_FFFF);
    chk(1, "abort_drsp_err", 32'(de[1]), 32'h0, 32'h1);
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (drv[1]) seen++;
    end
    chk(1, "abort_no_response", 32'(seen), 32'h0, 32'hFFFF_FFFF);
    d_xact(1, 1'b0, 32'h8, 4'hF, 32'h0, 4, 32'hCAFE_F00D, 1'b0, "rd_8_after_abort");
  endtask

  task automatic stream_test();
    logic [31:0] exp_q [$];
    logic [31:0] v;
    int          k;
    int          nresp;
    int          t_acc;
    int          t_prev;
    bit          acc;
    for (int j = 0; j < 4; j++) begin
      v = 32'h1000_0000 + 32'(j) * 32'h0101_0101;
      d_xact(2, 1'b1, 32'(j * 4), 4'hF, v, 1, 32'h0, 1'b0, "wr_stream");
      exp_q.push_back(v);
    end
    k = 0; nresp = 0; t_acc = -1; t_prev = -1;
    @(posedge clk);
    #1;
    iv[2] = 1'b1;
    ia[2] = 32'h0;
    for (int n = 0; n < 40 && nresp < 4; n++) begin
      @(negedge clk);
      if (irv[2]) begin
        if (exp_q.size() > 0) chk(2, "stream_data", ird[2], exp_q.pop_front(), 32'hFFFF_FFFF);
        if (t_prev < 0) chk(2, "stream_latency", 32'(cyc - t_acc), 32'd1, 32'hFFFF_FFFF);
        else chk(2, "stream_spacing", 32'(cyc - t_prev), 32'd2, 32'hFFFF_FFFF);
        t_prev = cyc;
        nresp++;
      end
      acc = ir[2];
      if (acc && t_acc < 0) t_acc = cyc;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k == 4) iv[2] = 1'b0;
        else ia[2] = 32'(k * 4);
      end
    end
    iv[2] = 1'b0;
    chk(2, "stream_count", 32'(nresp), 32'd4, 32'hFFFF_FFFF);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0;
      iv[g] = 1'b0; ia[g] = 32'h0;
      dv[g] = 1'b0; da[g] = 32'h0; dwe[g] = 1'b0; dbe[g] = 4'h0; dwd[g] = 32'h0;
      m_busy[g] = 0; m_age[g] = 0; m_last_i[g] = 1'b1;
      m_rsp_d[g] = 1'b0; m_rsp_err[g] = 1'b0;
      m_rsp_data[g] = 32'h0; m_rsp_mask[g] = 32'h0;
      for (int i = 0; i < 256; i++) begin
        m_mem[g][i]   = 32'h0;
        m_known[g][i] = 4'h0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
    @(negedge clk);
    chk(0, "reset_drsp_valid", 32'(drv[0]), 32'h0, 32'h1);
    chk(0, "reset_drsp_rdata", drd[0], 32'h0, 32'hFFFF_FFFF);
    chk(0, "reset_irsp_data", ird[0], 32'h0, 32'hFFFF_FFFF);

    d_xact(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, "wr_10");
    d_xact(0, 1'b0, 32'h10, 4'hF, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, "rd_10");
    d_xact(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 2, 32'h0, 1'b0, "wr_20");
    d_xact(0, 1'b1, 32'h20, 4'h2, 32'hAABB_CCDD, 2, 32'h0, 1'b0, "wr_20_be2");
    d_xact(0, 1'b0, 32'h20, 4'hF, 32'h0, 2, 32'h1122_CC44, 1'b0, "rd_20_merged");
    d_xact(0, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, 2, 32'h0, 1'b0, "wr_20_be0");
    d_xact(0, 1'b0, 32'h20, 4'hF, 32'h0, 2, 32'h1122_CC44, 1'b0, "rd_20_after_be0");
    d_xact(0, 1'b1, 32'h0, 4'hF, 32'h55AA_55AA, 2, 32'h0, 1'b0, "wr_0");
    d_xact(0, 1'b0, 32'h400, 4'hF, 32'h0, 2, 32'h0, 1'b1, "rd_400_range");
    d_xact(0, 1'b0, 32'h13, 4'hF, 32'h0, 2, 32'h0, 1'b1, "rd_13_misaligned");
    d_xact(0, 1'b1, 32'h400, 4'hF, 32'hFFFF_FFFF, 2, 32'h0, 1'b1, "wr_400_range");
    d_xact(0, 1'b0, 32'h0, 4'hF, 32'h0, 2, 32'h55AA_55AA, 1'b0, "rd_0_intact");

    arb_test();
    reset_abort_test();
    stream_test();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
